// File: rtl/rv_arch_state_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Package : defs
// Brief   : Shared constants and types for the architectural-state slice.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package defs;
   localparam int BIN_DIG = 32;   // default data / PC width
   localparam int PC_STEP = 4;    // sequential instruction stride in bytes

   typedef logic [BIN_DIG-1:0] word_t;
   typedef logic [4:0]         reg_addr_t;
endpackage
`default_nettype wire

// File: rtl/rv_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : rv_scoreboard
// Brief   : One busy bit per architectural register. Issue reserves a
//           destination, writeback releases it, and a bypassed operand
//           reads as ready.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module rv_scoreboard #(
   parameter int NREG = 32,
   parameter int NRP  = 2,
   parameter int AW   = $clog2(NREG)
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    issue_valid_i,
   input  logic [AW-1:0]           issue_rd_i,
   input  logic                    wb_valid_i,
   input  logic [AW-1:0]           wb_addr_i,
   input  logic [NRP-1:0][AW-1:0]  rd_addr_i,
   output logic [NRP-1:0]          rd_busy_o
);

   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_next;

   // Clear on writeback first, then set on issue, so a same-cycle
   // reservation of the register being written back stays outstanding.
   always_comb begin
      busy_next = busy;
      if (wb_valid_i) begin
         busy_next[wb_addr_i] = 1'b0;
      end
      if (issue_valid_i && issue_rd_i != '0) begin
         busy_next[issue_rd_i] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   // Busy vector state; reset drops every outstanding reservation.
   always_ff @(posedge CLK) begin
      if (RST) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

   // Operand-not-ready per read port, masked when the value is being bypassed.
   always_comb begin
      rd_busy_o = '0;
      for (int p = 0; p < NRP; p++) begin
         rd_busy_o[p] = busy[rd_addr_i[p]]
                        & ~(wb_valid_i && (wb_addr_i == rd_addr_i[p]));
      end
   end

endmodule
`default_nettype wire

// File: rtl/rv_arch_state.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : rv_arch_state
// Brief   : Architectural state: program counter with redirect/stall,
//           multi-ported register file with write-through bypass, and the
//           destination-register scoreboard.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module rv_arch_state
   import defs::*;
#(
   parameter  int              XLEN     = BIN_DIG,
   parameter  int              NREG     = 32,
   parameter  int              NRP      = 2,
   parameter  logic [XLEN-1:0] RESET_PC = '0,
   localparam int              AW       = $clog2(NREG)
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     stall_i,
   input  logic                     redirect_valid_i,
   input  logic [XLEN-1:0]          redirect_pc_i,
   output logic [XLEN-1:0]          pc_o,
   input  logic [NRP-1:0][AW-1:0]   rd_addr_i,
   output logic [NRP-1:0][XLEN-1:0] rd_data_o,
   output logic [NRP-1:0]           rd_busy_o,
   input  logic                     wb_valid_i,
   input  logic [AW-1:0]            wb_addr_i,
   input  logic [XLEN-1:0]          wb_data_i,
   input  logic                     issue_valid_i,
   input  logic [AW-1:0]            issue_rd_i
);

   logic [XLEN-1:0] regs [NREG];

   // PC: redirect beats stall; targets are forced word aligned; increment wraps.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pc_o <= RESET_PC;
      end else if (redirect_valid_i) begin
         pc_o <= {redirect_pc_i[XLEN-1:2], 2'b00};
      end else if (!stall_i) begin
         pc_o <= pc_o + XLEN'(PC_STEP);
      end
   end

   // Register file write; x0 is hardwired and never stored.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int r = 0; r < NREG; r++) begin
            regs[r] <= '0;
         end
      end else if (wb_valid_i && wb_addr_i != '0) begin
         regs[wb_addr_i] <= wb_data_i;
      end
   end

   // Combinational read ports: x0 reads zero, same-cycle writeback is forwarded.
   always_comb begin
      rd_data_o = '0;
      for (int p = 0; p < NRP; p++) begin
         if (rd_addr_i[p] == '0) begin
            rd_data_o[p] = '0;
         end else if (wb_valid_i && wb_addr_i == rd_addr_i[p]) begin
            rd_data_o[p] = wb_data_i;
         end else begin
            rd_data_o[p] = regs[rd_addr_i[p]];
         end
      end
   end

   rv_scoreboard #(
      .NREG (NREG),
      .NRP  (NRP),
      .AW   (AW)
   ) u_scoreboard (
      .CLK           (CLK),
      .RST           (RST),
      .issue_valid_i (issue_valid_i),
      .issue_rd_i    (issue_rd_i),
      .wb_valid_i    (wb_valid_i),
      .wb_addr_i     (wb_addr_i),
      .rd_addr_i     (rd_addr_i),
      .rd_busy_o     (rd_busy_o)
   );

endmodule
`default_nettype wire

// File: tb/tb_rv_arch_state.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_rv_arch_state
// Brief   : Self-checking bench for rv_arch_state with a behavioural model.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_rv_arch_state;

   logic             CLK = 1'b0;
   logic             RST;
   logic             stall;
   logic             redirect_valid;
   logic [31:0]      redirect_pc;
   logic [31:0]      pc;
   logic [1:0][4:0]  rd_addr;
   logic [1:0][31:0] rd_data;
   logic [1:0]       rd_busy;
   logic             wb_valid;
   logic [4:0]       wb_addr;
   logic [31:0]      wb_data;
   logic             issue_valid;
   logic [4:0]       issue_rd;

   int checks = 0;
   int errors = 0;

   // Behavioural model of the architectural state
   logic [31:0] pc_m;
   logic [31:0] reg_m [32];
   bit          busy_m [32];

   always #5 CLK = ~CLK;

   rv_arch_state dut (
      .CLK              (CLK),
      .RST              (RST),
      .stall_i          (stall),
      .redirect_valid_i (redirect_valid),
      .redirect_pc_i    (redirect_pc),
      .pc_o             (pc),
      .rd_addr_i        (rd_addr),
      .rd_data_o        (rd_data),
      .rd_busy_o        (rd_busy),
      .wb_valid_i       (wb_valid),
      .wb_addr_i        (wb_addr),
      .wb_data_i        (wb_data),
      .issue_valid_i    (issue_valid),
      .issue_rd_i       (issue_rd)
   );

   // Apply the architectural update rules for the inputs present at an edge.
   task automatic model_edge();
      if (RST) begin
         pc_m = 32'd0;
         for (int r = 0; r < 32; r++) begin
            reg_m[r]  = 32'd0;
            busy_m[r] = 1'b0;
         end
      end else begin
         if (redirect_valid) pc_m = redirect_pc & 32'hFFFF_FFFC;
         else if (!stall)    pc_m = pc_m + 32'd4;
         if (wb_valid && wb_addr != 0) reg_m[wb_addr] = wb_data;
         if (wb_valid) busy_m[wb_addr] = 1'b0;
         if (issue_valid && issue_rd != 0) busy_m[issue_rd] = 1'b1;
      end
   endtask

   function automatic logic [31:0] exp_data(input logic [4:0] a);
      if (a == 0) return 32'd0;
      if (wb_valid && wb_addr == a) return wb_data;
      return reg_m[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      if (a == 0) return 1'b0;
      if (wb_valid && wb_addr == a) return 1'b0;
      return busy_m[a];
   endfunction

   // One rising edge; returns 1 time unit after it with the model updated.
   task automatic step();
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      stall = 0; redirect_valid = 0; redirect_pc = 0;
      wb_valid = 0; wb_addr = 0; wb_data = 0;
      issue_valid = 0; issue_rd = 0;
   endtask

   task automatic test_reset();
      RST = 1;
      stall = 1; redirect_valid = 1; redirect_pc = 32'h0000_1234;
      wb_valid = 1; wb_addr = 5'd9; wb_data = 32'hCAFE_F00D;
      issue_valid = 1; issue_rd = 5'd9;
      rd_addr[0] = 5'd9; rd_addr[1] = 5'd1;
      step(); step();
      RST = 0;
      idle_inputs();
      #1;
      checks++;
      if (pc !== 32'd0) begin
         errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'd0);
      end
      checks++;
      if (rd_data[0] !== 32'd0 || rd_busy[0] !== 1'b0) begin
         errors++; $display("FAIL reset_x9: got data %h busy %b expected 0 0", rd_data[0], rd_busy[0]);
      end
      for (int k = 1; k <= 3; k++) begin
         step();
         checks++;
         if (pc !== 32'(4 * k)) begin
            errors++; $display("FAIL free_run_pc%0d: got %h expected %h", k, pc, 32'(4 * k));
         end
      end
   endtask

   task automatic test_pc();
      redirect_valid = 1; redirect_pc = 32'h10;
      step();
      redirect_valid = 1; stall = 1; redirect_pc = 32'h203;
      step();
      checks++;
      if (pc !== 32'h200) begin
         errors++; $display("FAIL redirect_over_stall: got %h expected %h", pc, 32'h200);
      end
      redirect_valid = 1; stall = 0; redirect_pc = 32'h10;
      step();
      redirect_valid = 0; stall = 1;
      step(); step();
      checks++;
      if (pc !== 32'h10) begin
         errors++; $display("FAIL stall_hold: got %h expected %h", pc, 32'h10);
      end
      redirect_valid = 1; stall = 0; redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect_valid = 0;
      step();
      checks++;
      if (pc !== 32'h0) begin
         errors++; $display("FAIL pc_wrap: got %h expected %h", pc, 32'h0);
      end
   endtask

   task automatic test_regfile();
      wb_valid = 1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
      rd_addr[0] = 5'd5; rd_addr[1] = 5'd5;
      #1;
      checks++;
      if (rd_data[0] !== 32'hDEAD_BEEF || rd_data[1] !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL bypass_x5: got %h %h expected %h", rd_data[0], rd_data[1], 32'hDEAD_BEEF);
      end
      step();
      wb_valid = 1; wb_addr = 5'd0; wb_data = 32'h1234_5678;
      rd_addr[0] = 5'd0; rd_addr[1] = 5'd5;
      #1;
      checks++;
      if (rd_data[0] !== 32'd0 || rd_data[1] !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL wb_x0_same_cycle: got %h %h expected 0 deadbeef", rd_data[0], rd_data[1]);
      end
      step();
      wb_valid = 0;
      #1;
      checks++;
      if (rd_data[0] !== 32'd0 || rd_data[1] !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL x0_after_wb: got %h %h expected 0 deadbeef", rd_data[0], rd_data[1]);
      end
   endtask

   task automatic test_scoreboard();
      idle_inputs();
      rd_addr[0] = 5'd7; rd_addr[1] = 5'd7;
      issue_valid = 1; issue_rd = 5'd7;
      step();
      issue_valid = 0;
      #1;
      checks++;
      if (rd_busy !== 2'b11) begin
         errors++; $display("FAIL busy_after_issue: got %b expected %b", rd_busy, 2'b11);
      end
      wb_valid = 1; wb_addr = 5'd7; wb_data = 32'h0000_00A5;
      #1;
      checks++;
      if (rd_busy !== 2'b00 || rd_data[0] !== 32'hA5) begin
         errors++; $display("FAIL busy_bypass: got busy %b data %h expected 00 a5", rd_busy, rd_data[0]);
      end
      step();
      wb_valid = 0;
      #1;
      checks++;
      if (rd_busy !== 2'b00) begin
         errors++; $display("FAIL busy_cleared: got %b expected %b", rd_busy, 2'b00);
      end
      issue_valid = 1; issue_rd = 5'd7;
      wb_valid = 1; wb_addr = 5'd7; wb_data = 32'h77;
      step();
      idle_inputs();
      #1;
      checks++;
      if (rd_busy !== 2'b11 || rd_data[1] !== 32'h77) begin
         errors++; $display("FAIL set_wins: got busy %b data %h expected 11 77", rd_busy, rd_data[1]);
      end
   endtask

   task automatic test_reset_midop();
      idle_inputs();
      rd_addr[0] = 5'd3; rd_addr[1] = 5'd3;
      issue_valid = 1; issue_rd = 5'd3;
      step();
      issue_valid = 0;
      RST = 1;
      step();
      RST = 0;
      #1;
      checks++;
      if (rd_busy !== 2'b00 || rd_data[0] !== 32'd0) begin
         errors++; $display("FAIL reset_midop: got busy %b data %h expected 00 0", rd_busy, rd_data[0]);
      end
      wb_valid = 1; wb_addr = 5'd3; wb_data = 32'h55;
      step();
      wb_valid = 0;
      #1;
      checks++;
      if (rd_busy !== 2'b00 || rd_data[0] !== 32'h55) begin
         errors++; $display("FAIL wb_after_reset: got busy %b data %h expected 00 55", rd_busy, rd_data[0]);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         RST            = ($urandom_range(0, 59) == 0);
         stall          = $urandom_range(0, 2) == 0;
         redirect_valid = $urandom_range(0, 4) == 0;
         redirect_pc    = $urandom();
         wb_valid       = $urandom_range(0, 1);
         wb_addr        = 5'($urandom_range(0, 7));
         wb_data        = $urandom();
         issue_valid    = $urandom_range(0, 1);
         issue_rd       = 5'($urandom_range(0, 7));
         rd_addr[0]     = 5'($urandom_range(0, 7));
         rd_addr[1]     = ($urandom_range(0, 3) == 0) ? rd_addr[0] : 5'($urandom_range(0, 31));
         #1;
         for (int p = 0; p < 2; p++) begin
            checks++;
            if (rd_data[p] !== exp_data(rd_addr[p]) || rd_busy[p] !== exp_busy(rd_addr[p])) begin
               errors++;
               $display("FAIL rand_read%0d cycle %0d addr %0d: got data %h busy %b expected %h %b",
                        p, n, rd_addr[p], rd_data[p], rd_busy[p], exp_data(rd_addr[p]), exp_busy(rd_addr[p]));
            end
         end
         step();
         checks++;
         if (pc !== pc_m) begin
            errors++; $display("FAIL rand_pc cycle %0d: got %h expected %h", n, pc, pc_m);
         end
      end
      RST = 0;
      idle_inputs();
   endtask

   initial begin
      pc_m = 32'd0;
      for (int r = 0; r < 32; r++) begin
         reg_m[r] = 32'd0; busy_m[r] = 1'b0;
      end
      idle_inputs();
      RST = 1;
      rd_addr[0] = 5'd0; rd_addr[1] = 5'd0;
      #2;
      test_reset();
      test_pc();
      test_regfile();
      test_scoreboard();
      test_reset_midop();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rv_arch_state.md
RV_ARCH_STATE -- requirements
Module: rv_arch_state

Interface
REQ-001 Parameter XLEN, default 32, data and PC width in bits.
REQ-002 Parameter NREG, default 32, architectural register count (power of two); AW = log2(NREG).
REQ-003 Parameter NRP, default 2, number of independent register read ports.
REQ-004 Parameter RESET_PC, default 0, PC value after reset.
REQ-005 CLK  in  1  clock; all state updates on the rising edge.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 stall_i  in  1  hold PC this cycle.
REQ-008 redirect_valid_i  in  1  control-hazard redirect request.
REQ-009 redirect_pc_i  in  XLEN  redirect target.
REQ-010 pc_o  out  XLEN  current PC, driven from a register.
REQ-011 rd_addr_i  in  NRP x AW  read-port addresses.
REQ-012 rd_data_o  out  NRP x XLEN  read-port data.
REQ-013 rd_busy_o  out  NRP  read-port operand-not-ready flags.
REQ-014 wb_valid_i / wb_addr_i / wb_data_i  in  1 / AW / XLEN  writeback port.
REQ-015 issue_valid_i / issue_rd_i  in  1 / AW  destination reservation at issue.

Function
REQ-016 PC next-state priority: RST, then redirect_valid_i (pc <= redirect_pc_i with bits [1:0] forced to 0), then stall_i (hold), else pc + 4.
REQ-017 PC increment wraps modulo 2^XLEN: pc = 2^XLEN-4 steps to 0 with no flag.
REQ-018 Redirect and stall asserted together: redirect wins, with no extra hold cycle.
REQ-019 Register write occurs at the edge when wb_valid_i=1 and wb_addr_i != 0; register 0 is never written.
REQ-020 Reads are combinational, with zero added latency: rd_data_o[i] = 0 if rd_addr_i[i]=0.
REQ-021 Otherwise rd_data_o[i] = wb_data_i if wb_valid_i and wb_addr_i == rd_addr_i[i] (write-through bypass).
REQ-022 Otherwise rd_data_o[i] = the stored register value.
REQ-023 Scoreboard: one busy bit per register; busy[0] is constant 0.
REQ-024 A busy bit is set at the edge when issue_valid_i=1 and issue_rd_i != 0.
REQ-025 A busy bit is cleared at the edge when wb_valid_i=1 for that address.
REQ-026 Set and clear of the same register in the same cycle: set wins (new producer outstanding).
REQ-027 Issue and writeback are honoured independently of stall_i and redirect_valid_i.
REQ-028 rd_busy_o[i] = busy[rd_addr_i[i]] AND NOT (wb_valid_i AND wb_addr_i == rd_addr_i[i]), so a bypassed operand reads as ready.
REQ-029 Multiple read ports on the same address return identical data and busy flags.
REQ-030 Issue to a register that is already busy leaves it busy; there is no counter and no error.

Reset
REQ-031 While RST=1: pc_o <= RESET_PC, all registers <= 0, all busy bits <= 0.
REQ-032 RST overrides redirect, stall, writeback and issue in the same cycle.
REQ-033 The first cycle after RST deasserts shows pc_o = RESET_PC; the next unstalled edge gives RESET_PC+4.
REQ-034 Reset asserted mid-operation discards all in-flight reservations; the following writebacks write data but find busy already clear.

Structure
REQ-035 The shared package defs holds XLEN default (BIN_DIG), the PC_STEP=4 constant, and typedefs word_t and reg_addr_t.
REQ-036 The scoreboard (busy vector, set/clear logic, rd_busy generation) is a sub-module named rv_scoreboard.
REQ-037 PC logic and the register array stay in rv_arch_state; the register array has no reset other than REQ-031.

Verification
REQ-038 Reset then 3 free-running cycles -> pc_o = 0, 4, 8, 12.
REQ-039 pc_o=0x10, stall_i=1 and redirect_valid_i=1 with redirect_pc_i=0x203 -> next pc_o=0x200; with stall only -> pc_o stays 0x10.
REQ-040 pc_o=0xFFFFFFFC, no stall -> next pc_o=0x00000000.
REQ-041 wb x5=0xDEADBEEF while reading x5 on both ports in the same cycle -> both ports return 0xDEADBEEF combinationally; writeback to x0 -> x0 still reads 0.
REQ-042 Issue x7 -> rd_busy=1 on reading x7; in the wb x7 cycle -> rd_busy=0 with bypassed data; issue x7 and wb x7 together -> x7 remains busy.
REQ-043 Issue x3, then RST for one cycle -> busy clear and x3 reads 0; a subsequent wb x3=0x55 -> x3 reads 0x55 with rd_busy=0.
